// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   Serial-to-parallel UART receiver: 8 data bits LSB first, even parity,
//   one stop bit, idle-high line. The line is oversampled OVERSAMPLE times
//   per bit. Each received byte is presented with a sticky ready flag and
//   status bits.
//
// Build option
//   UART_RX_MAJORITY_VOTE_EN  when defined, every bit is the 2-of-3 majority
//                             of the synchronized line at bit-relative ticks
//                             OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2.
//                             When undefined, one sample is taken at tick
//                             OVERSAMPLE/2-1.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line bit rate
//   OVERSAMPLE  ticks per bit (even, >= 8)
//
// Ports
//   clk           in   system clock, rising edge
//   nrst          in   synchronous active-low reset
//   rx            in   asynchronous serial line
//   rx_flag_clr   in   one-cycle pulse, clears rx_flag and overrun
//   Rx_Data       out  last byte received with a good stop bit
//   parity_error  out  parity result for the byte in Rx_Data
//   frame_error   out  last frame had a stop bit of 0
//   overrun       out  a byte completed while rx_flag was already set
//   rx_flag       out  sticky "byte available"
//   rx_busy       out  receiver state machine is not idle
//
// State table
//   state  | meaning
//   IDLE   | waiting for a 1->0 transition on the synchronized line
//   START  | timing to mid start bit, confirming the line is still low
//   DATA   | sampling 8 data bits, one per OVERSAMPLE ticks
//   PARITY | sampling the parity bit and forming the parity check
//   STOP   | sampling the stop bit and updating the output registers

module uart_rx_frame #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  input  logic       rx_flag_clr,
  output logic [7:0] Rx_Data,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun,
  output logic       rx_flag,
  output logic       rx_busy
);

  // Clocks per tick. A non-integer ratio rounds down, so the receiver runs
  // slightly fast; the mid-bit sampling tolerates the small rate error.
  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int TC_W  = $clog2(OVERSAMPLE);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The last vote is taken at tick OVERSAMPLE/2, so the decision lands one
  // tick later than in the single-sample build.
  localparam int START_DEC = OVERSAMPLE / 2;
`else
  localparam int START_DEC = OVERSAMPLE / 2 - 1;
`endif

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TC_W-1:0]  TC_LAST   = TC_W'(OVERSAMPLE - 1);
  localparam logic [TC_W-1:0]  TC_START  = TC_W'(START_DEC);

  if (DIV < 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_param
    $error("uart_rx_frame: requires CLK_FREQ/(BAUD*OVERSAMPLE) >= 2 and even OVERSAMPLE >= 8");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_s_q, rx_s_d;
  logic              rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [TC_W-1:0]   tc_q, tc_d;
  logic [2:0]        bc_q, bc_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_err_q, par_err_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              parity_error_q, parity_error_d;
  logic              frame_error_q, frame_error_d;
  logic              overrun_q, overrun_d;
  logic              rx_flag_q, rx_flag_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0]        vote_q, vote_d;
`endif

  logic              tick;
  logic [TC_W-1:0]   dec_tc;
  logic              sample_now;
  logic              bit_val;
  logic              done_good;
  logic              done_bad;

  // The tick generator only runs outside IDLE; it is restarted on the start
  // edge so that bit timing is phased to the detected transition.
  assign tick = (state_q != IDLE) && (div_q == DIV_LAST);

  // START decides at mid start bit; afterwards tc has been re-phased so the
  // decision for every later bit falls on the tc wrap.
  assign dec_tc     = (state_q == START) ? TC_START : TC_LAST;
  assign sample_now = tick && (tc_q == dec_tc);

`ifdef UART_RX_MAJORITY_VOTE_EN
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
  assign bit_val = rx_s_q;
`endif

  always_comb begin
    rx_meta_d      = rx;
    rx_s_d         = rx_meta_q;
    rx_prev_d      = rx_s_q;
    state_d        = state_q;
    div_d          = div_q;
    tc_d           = tc_q;
    bc_d           = bc_q;
    shift_d        = shift_q;
    par_err_d      = par_err_q;
    rx_data_d      = rx_data_q;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    overrun_d      = overrun_q;
    rx_flag_d      = rx_flag_q;
    done_good      = 1'b0;
    done_bad       = 1'b0;

    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        tc_d = (tc_q == TC_LAST) ? '0 : tc_q + TC_W'(1);
      end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    vote_d = vote_q;
    if (tick && (tc_q == dec_tc - TC_W'(2))) vote_d[0] = rx_s_q;
    if (tick && (tc_q == dec_tc - TC_W'(1))) vote_d[1] = rx_s_q;
`endif

    case (state_q)
      IDLE: begin
        // Only a real 1->0 transition starts a frame; a held-low line
        // (break) cannot retrigger.
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          tc_d    = '0;
          div_d   = '0;
        end
      end
      START: begin
        if (sample_now) begin
          if (bit_val) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            tc_d    = '0;
            bc_d    = '0;
          end
        end
      end
      DATA: begin
        if (sample_now) begin
          shift_d = {bit_val, shift_q[7:1]};
          bc_d    = bc_q + 3'd1;
          if (bc_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (sample_now) begin
          par_err_d = (^shift_q) ^ bit_val;
          state_d   = STOP;
        end
      end
      STOP: begin
        // Return to IDLE at mid-stop so a back-to-back start edge half a
        // bit later is still caught.
        if (sample_now) begin
          state_d   = IDLE;
          done_good = bit_val;
          done_bad  = !bit_val;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_flag_clr) begin
      rx_flag_d = 1'b0;
      overrun_d = 1'b0;
    end

    // A completion in the same cycle as a clear takes precedence for the
    // flag; the clear still prevents this completion from counting as an
    // overrun.
    if (done_good) begin
      rx_data_d      = shift_q;
      parity_error_d = par_err_q;
      frame_error_d  = 1'b0;
      rx_flag_d      = 1'b1;
      if (rx_flag_q && !rx_flag_clr) overrun_d = 1'b1;
    end

    if (done_bad) begin
      frame_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q        <= IDLE;
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      rx_prev_q      <= 1'b1;
      div_q          <= '0;
      tc_q           <= '0;
      bc_q           <= '0;
      shift_q        <= '0;
      par_err_q      <= 1'b0;
      rx_data_q      <= '0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
      rx_flag_q      <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rx_meta_q      <= rx_meta_d;
      rx_s_q         <= rx_s_d;
      rx_prev_q      <= rx_prev_d;
      div_q          <= div_d;
      tc_q           <= tc_d;
      bc_q           <= bc_d;
      shift_q        <= shift_d;
      par_err_q      <= par_err_d;
      rx_data_q      <= rx_data_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      overrun_q      <= overrun_d;
      rx_flag_q      <= rx_flag_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q         <= vote_d;
`endif
    end
  end

  assign Rx_Data      = rx_data_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign overrun      = overrun_q;
  assign rx_flag      = rx_flag_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame: directed frames from the test plan followed by
// random frames, all checked against a line-level reference receiver.

module tb_uart_rx_frame;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int OS       = 16;
  localparam int DIV      = CLK_FREQ / (BAUD * OS);
  localparam int CPB      = DIV * OS;
  localparam int FRAME    = 11 * CPB;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       nrst;
  logic       rx;
  logic       rx_flag_clr;
  logic [7:0] Rx_Data;
  logic       parity_error;
  logic       frame_error;
  logic       overrun;
  logic       rx_flag;
  logic       rx_busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model of the output registers
  logic [7:0] m_data;
  logic       m_perr, m_ferr, m_ovr, m_flag;

  uart_rx_frame #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .rx          (rx),
    .rx_flag_clr (rx_flag_clr),
    .Rx_Data     (Rx_Data),
    .parity_error(parity_error),
    .frame_error (frame_error),
    .overrun     (overrun),
    .rx_flag     (rx_flag),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"}, 32'(Rx_Data), 32'(m_data));
    check({tag, ".perr"}, 32'(parity_error), 32'(m_perr));
    check({tag, ".ferr"}, 32'(frame_error), 32'(m_ferr));
    check({tag, ".ovr"},  32'(overrun), 32'(m_ovr));
    check({tag, ".flag"}, 32'(rx_flag), 32'(m_flag));
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_flag = 1'b0;
  endtask

  // clr: a clear pulse was sampled on the edge just observed
  // done: a frame completed on that edge, good = stop bit was 1
  task automatic model_step(input bit clr, input bit done, input bit good,
                            input logic [7:0] d, input bit pe);
    if (done && good) begin
      m_ovr  = clr ? 1'b0 : (m_ovr | m_flag);
      m_data = d;
      m_perr = pe;
      m_ferr = 1'b0;
      m_flag = 1'b1;
    end else begin
      if (done) m_ferr = 1'b1;
      if (clr) begin
        m_flag = 1'b0;
        m_ovr  = 1'b0;
      end
    end
  endtask

  // Drives one frame cycle by cycle; rx value w[i] is driven at negedge i.
  // The reference receiver reads the line at bit centres (cycle b*CPB+CPB/2),
  // or takes the majority of the centre and one tick either side; the result
  // appears three clocks after the deciding sample (two sync flops plus the
  // output register), i.e. on the edge after the line value passes rx_s.
  task automatic send_frame(input string tag, input logic [7:0] d, input bit bad_par,
                            input bit bad_stop, input int gap, input int glitch_at,
                            input int clr_at);
    bit [10:0]  bits;
    bit [10:0]  s;
    bit         w [0:FRAME+511];
    int         len, dec, done, c;
    logic [7:0] r_data;
    bit         r_pe;
    len  = FRAME + gap;
    bits = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < len; i++) begin
      w[i] = (i < FRAME) ? bits[i / CPB] : 1'b1;
      if (i == glitch_at) w[i] = 1'b0;
    end
    for (int b = 0; b < 11; b++) begin
      c = b * CPB + CPB / 2;
      if (MAJ != 0) s[b] = (int'(w[c-DIV]) + int'(w[c]) + int'(w[c+DIV])) >= 2;
      else          s[b] = w[c];
    end
    r_data = s[8:1];
    r_pe   = (^r_data) ^ s[9];
    dec    = 10 * CPB + CPB / 2 + MAJ * DIV;
    done   = dec + 3;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      model_step(clr_at >= 0 && i == clr_at + 1, i == done && s[0] == 1'b0,
                 s[10], r_data, r_pe);
      if (i == done - 1) begin
        check({tag, ".busy_pre"}, 32'(rx_busy), 32'd1);
        check_all({tag, ".pre"});
      end
      if (i == done) begin
        check_all(tag);
        check({tag, ".busy_post"}, 32'(rx_busy), 32'd0);
      end
      rx          = w[i];
      rx_flag_clr = (i == clr_at);
    end
  endtask

  task automatic idle(input int n, input int clr_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_step(clr_at >= 0 && i == clr_at + 1, 1'b0, 1'b0, 8'h00, 1'b0);
      rx          = 1'b1;
      rx_flag_clr = (i == clr_at);
    end
  endtask

  initial begin
    logic [7:0] rd;
    bit         bp, bs;
    int         gap, sel, clr_at;
    bit [10:0]  rbits;

    nrst        = 1'b0;
    rx          = 1'b1;
    rx_flag_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    check("reset.busy", 32'(rx_busy), 32'd0);
    nrst = 1'b1;
    idle(50, -1);

    // Good frame and exact completion latency
    send_frame("a5", 8'hA5, 1'b0, 1'b0, 40, -1, -1);
    check("a5.data_const", 32'(Rx_Data), 32'hA5);
    idle(20, 5);
    check_all("clr1");

    // Wrong parity bit
    send_frame("07", 8'h07, 1'b1, 1'b0, 40, -1, -1);
    check("07.perr_const", 32'(parity_error), 32'd1);
    idle(20, 5);

    // 40-clock low pulse: false start, no frame
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 50) check("break.busy_mid", 32'(rx_busy), 32'd1);
      if (i == 100) begin
        check("break.busy_end", 32'(rx_busy), 32'd0);
        check_all("break");
      end
      rx = (i < 40) ? 1'b0 : 1'b1;
    end

    // Stop bit 0: frame error, byte and flag untouched
    send_frame("3c", 8'h3C, 1'b0, 1'b1, 40, -1, -1);
    check("3c.ferr_const", 32'(frame_error), 32'd1);
    check("3c.data_const", 32'(Rx_Data), 32'h07);

    // Back-to-back frames without clearing: overrun
    send_frame("11", 8'h11, 1'b0, 1'b0, 0, -1, -1);
    send_frame("22", 8'h22, 1'b0, 1'b0, 40, -1, -1);
    check("22.ovr_const", 32'(overrun), 32'd1);
    idle(20, 5);
    check_all("clr2");

    // Clear in the completion cycle: completion wins
    send_frame("33", 8'h33, 1'b0, 1'b0, 40, -1, 10 * CPB + CPB / 2 + MAJ * DIV + 2);
    check("33.flag_const", 32'(rx_flag), 32'd1);

    // Reset during data bit 3 (line bit 4)
    rbits = {1'b1, ^8'hC3, 8'hC3, 1'b0};
    for (int i = 0; i < 703; i++) begin
      @(negedge clk);
      if (i == 650) check("rst.busy_before", 32'(rx_busy), 32'd1);
      if (i == 702) begin
        model_reset();
        check_all("rst");
        check("rst.busy", 32'(rx_busy), 32'd0);
      end
      if (i < 700) begin
        rx   = rbits[i / CPB];
        nrst = 1'b1;
      end else if (i < 702) begin
        rx   = 1'b1;
        nrst = 1'b0;
      end else begin
        nrst = 1'b1;
      end
    end
    idle(300, -1);
    check("rst.busy_after", 32'(rx_busy), 32'd0);
    check_all("rst_after");
    send_frame("5a", 8'h5A, 1'b0, 1'b0, 40, -1, -1);
    idle(20, 5);

    // One-clock low glitch at the centre of data bit 2
    send_frame("ff_glitch", 8'hFF, 1'b0, 1'b0, 40, 3 * CPB + CPB / 2, -1);
    check("ff.data_const", 32'(Rx_Data), (MAJ != 0) ? 32'hFF : 32'hFB);
    check("ff.perr_const", 32'(parity_error), (MAJ != 0) ? 32'd0 : 32'd1);

    // Random frames
    for (int k = 0; k < 12; k++) begin
      rd  = 8'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 4) == 0);
      gap = bs ? int'($urandom_range(20, 300)) : int'($urandom_range(0, 300));
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      clr_at = -1;
      else if (sel == 1) clr_at = int'($urandom_range(0, FRAME - 2));
      else               clr_at = 10 * CPB + CPB / 2 + MAJ * DIV + 2;
      send_frame($sformatf("rnd%0d", k), rd, bp, bs, gap, -1, clr_at);
    end
    idle(20, -1);
    check_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
